// File: rtl/net_domain_link_tdm.sv
// net_domain_link_tdm: time-multiplexed ring link stage with one private FIFO
// per security domain. Admission is granted to a single domain per slot on a
// free-running schedule, so no domain's traffic can influence another's
// admission, occupancy or latency.
module net_domain_link_tdm #(
    parameter int unsigned p_msg_cnbits  = 41,
    parameter int unsigned p_msg_dnbits  = 32,
    parameter int unsigned p_num_domains = 2,
    parameter int unsigned p_depth       = 2,
    parameter int unsigned p_slot_cycles = 1,
    localparam int unsigned DW = (p_num_domains > 1) ? $clog2(p_num_domains) : 1,
    localparam int unsigned CW = $clog2(p_depth + 1)
) (
    input  logic                                    clk,
    input  logic                                    reset,
    input  logic                                    in_val,
    output logic                                    in_rdy,
    input  logic [DW-1:0]                           in_domain,
    input  logic [p_msg_cnbits-1:0]                 in_msg_control,
    input  logic [p_msg_dnbits-1:0]                 in_msg_data,
    output logic [DW-1:0]                           cur_slot,
    output logic [p_num_domains-1:0]                out_val,
    input  logic [p_num_domains-1:0]                out_rdy,
    output logic [p_num_domains*p_msg_cnbits-1:0]   out_msg_control,
    output logic [p_num_domains*p_msg_dnbits-1:0]   out_msg_data,
    output logic [p_num_domains*CW-1:0]             num_free
);

    localparam int unsigned N     = p_num_domains;
    localparam int unsigned C     = p_msg_cnbits;
    localparam int unsigned D     = p_msg_dnbits;
    localparam int unsigned MW    = C + D;
    localparam int unsigned PW    = $clog2(p_depth);
    localparam int unsigned CYC_W = (p_slot_cycles > 1) ? $clog2(p_slot_cycles) : 1;

    localparam logic [CW-1:0]    FULL_CNT  = CW'(p_depth);
    localparam logic [CYC_W-1:0] LAST_CYC  = CYC_W'(p_slot_cycles - 1);
    localparam logic [DW-1:0]    LAST_SLOT = DW'(p_num_domains - 1);

    // Slot schedule state
    logic [CYC_W-1:0] cyc_q, cyc_d;
    logic [DW-1:0]    cur_slot_q, cur_slot_d;

    // Per-domain FIFO state
    logic [CW-1:0] count_q  [N];
    logic [CW-1:0] count_d  [N];
    logic [PW-1:0] rd_ptr_q [N];
    logic [PW-1:0] rd_ptr_d [N];
    logic [PW-1:0] wr_ptr_q [N];
    logic [PW-1:0] wr_ptr_d [N];
    logic [MW-1:0] mem_q    [N][p_depth];
    logic [MW-1:0] mem_d    [N][p_depth];

    logic          slot_full_c;
    logic          enq_c;
    logic [N-1:0]  enq_vec_c;
    logic [N-1:0]  deq_vec_c;

    assign cur_slot = cur_slot_q;

    // Admission: only the slot owner may enter, and never into a full FIFO
    assign slot_full_c = (count_q[cur_slot_q] == FULL_CNT);
    assign in_rdy      = reset && (in_domain == cur_slot_q) && !slot_full_c;
    assign enq_c       = in_val && in_rdy;

    // Free-running slot counter, independent of traffic
    always_comb begin
        cyc_d      = cyc_q;
        cur_slot_d = cur_slot_q;
        if (cyc_q == LAST_CYC) begin
            cyc_d      = '0;
            cur_slot_d = (cur_slot_q == LAST_SLOT) ? '0 : cur_slot_q + DW'(1);
        end else begin
            cyc_d = cyc_q + CYC_W'(1);
        end
    end

    // Per-domain push/pop strobes
    always_comb begin
        enq_vec_c = '0;
        deq_vec_c = '0;
        for (int d = 0; d < N; d++) begin
            enq_vec_c[d] = enq_c && (cur_slot_q == DW'(d));
            deq_vec_c[d] = (count_q[d] != '0) && out_rdy[d];
        end
    end

    // FIFO next state: write at tail, pop at head, track occupancy
    always_comb begin
        for (int d = 0; d < N; d++) begin
            count_d[d]  = count_q[d];
            rd_ptr_d[d] = rd_ptr_q[d];
            wr_ptr_d[d] = wr_ptr_q[d];
            for (int e = 0; e < p_depth; e++) begin
                mem_d[d][e] = mem_q[d][e];
            end
        end
        for (int d = 0; d < N; d++) begin
            if (enq_vec_c[d]) begin
                mem_d[d][wr_ptr_q[d]] = {in_msg_control, in_msg_data};
                wr_ptr_d[d]           = wr_ptr_q[d] + PW'(1);
            end
            if (deq_vec_c[d]) begin
                rd_ptr_d[d] = rd_ptr_q[d] + PW'(1);
            end
            if (enq_vec_c[d] && !deq_vec_c[d]) begin
                count_d[d] = count_q[d] + CW'(1);
            end else if (!enq_vec_c[d] && deq_vec_c[d]) begin
                count_d[d] = count_q[d] - CW'(1);
            end
        end
    end

    // Outputs from registered state only; empty FIFOs present a zero payload
    always_comb begin
        out_val         = '0;
        out_msg_control = '0;
        out_msg_data    = '0;
        num_free        = '0;
        for (int d = 0; d < N; d++) begin
            out_val[d] = (count_q[d] != '0);
            if (count_q[d] != '0) begin
                out_msg_control[d*C +: C] = mem_q[d][rd_ptr_q[d]][MW-1 -: C];
                out_msg_data[d*D +: D]    = mem_q[d][rd_ptr_q[d]][D-1:0];
            end
            num_free[d*CW +: CW] = FULL_CNT - count_q[d];
        end
    end

    // State registers; reset discards all queued traffic and storage
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cyc_q      <= '0;
            cur_slot_q <= '0;
            for (int d = 0; d < N; d++) begin
                count_q[d]  <= '0;
                rd_ptr_q[d] <= '0;
                wr_ptr_q[d] <= '0;
                for (int e = 0; e < p_depth; e++) begin
                    mem_q[d][e] <= '0;
                end
            end
        end else begin
            cyc_q      <= cyc_d;
            cur_slot_q <= cur_slot_d;
            for (int d = 0; d < N; d++) begin
                count_q[d]  <= count_d[d];
                rd_ptr_q[d] <= rd_ptr_d[d];
                wr_ptr_q[d] <= wr_ptr_d[d];
                for (int e = 0; e < p_depth; e++) begin
                    mem_q[d][e] <= mem_d[d][e];
                end
            end
        end
    end

endmodule
